// File: rtl/triangle_fifo_merger_pkg.sv
// Shared constants, record type and width helpers for the triangle FIFO merger.
package tri_fifo_pkg;

   localparam int unsigned TRI_DATA_W = 224;

   typedef logic [TRI_DATA_W-1:0] tri_rec_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Index width that stays at least one bit for single-entry ranges.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/triangle_fifo_merger_if.sv
// Producer/consumer bundle of the triangle FIFO merger; master drives, slave is the merger.
interface triangle_fifo_merger_if
   import tri_fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = TRI_DATA_W,
   parameter int unsigned N_SRC     = 2,
   parameter int unsigned BUF_DEPTH = 4
) ();

   localparam int unsigned LVL_W = clog2(BUF_DEPTH + 1);

   logic [DATA_W-1:0]       prio_data;
   logic                    prio_push;
   logic [N_SRC*DATA_W-1:0] src_data;
   logic [N_SRC-1:0]        src_push;
   logic                    src_wait;
   logic [DATA_W-1:0]       out_data;
   logic                    out_push;
   logic                    fifo_full;
   logic                    fifo_prog_full;
   logic [LVL_W-1:0]        buf_level;
   logic                    overflow;

   modport master (
      output prio_data, prio_push, src_data, src_push, fifo_full, fifo_prog_full,
      input  src_wait, out_data, out_push, buf_level, overflow
   );

   modport slave (
      input  prio_data, prio_push, src_data, src_push, fifo_full, fifo_prog_full,
      output src_wait, out_data, out_push, buf_level, overflow
   );

endinterface

// File: rtl/triangle_fifo_merger_skid_buf.sv
// Circular skid buffer: N_WR write ports packed in ascending order after an optional pop.
module tri_skid_buf
   import tri_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = TRI_DATA_W,
   parameter int unsigned N_WR   = 2,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  logic [N_WR-1:0]               wr_en_i,
   input  logic [DATA_W-1:0]             wr_data_i [N_WR],
   input  logic                          pop_i,
   output logic [DATA_W-1:0]             rd_data_o,
   output logic [clog2(DEPTH+1)-1:0]     level_o,
   output logic                          empty_o,
   output logic                          drop_o
);

   localparam int unsigned PTR_W = idx_w(DEPTH);
   localparam int unsigned LVL_W = clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [N_WR-1:0]   wr_ok;
   logic [PTR_W-1:0]  wr_idx [N_WR];
   logic              do_pop;

   // Operands are always below 2*DEPTH, so one conditional subtract wraps them.
   function automatic logic [PTR_W-1:0] wrap(input int unsigned v);
      return PTR_W'((v >= DEPTH) ? v - DEPTH : v);
   endfunction

   always_comb begin
      int unsigned free_slots;
      int unsigned n_wr;
      do_pop     = pop_i && (level_q != '0);
      free_slots = DEPTH - 32'(level_q) + 32'(do_pop);
      n_wr       = 0;
      wr_ok      = '0;
      drop_o     = 1'b0;
      for (int unsigned i = 0; i < N_WR; i++) begin
         wr_idx[i] = wrap(32'(wr_ptr_q) + n_wr);
         if (wr_en_i[i]) begin
            if (n_wr < free_slots) begin
               wr_ok[i] = 1'b1;
               n_wr     = n_wr + 1;
            end else begin
               drop_o = 1'b1;
            end
         end
      end
      rd_ptr_d = do_pop ? wrap(32'(rd_ptr_q) + 1) : rd_ptr_q;
      wr_ptr_d = wrap(32'(wr_ptr_q) + n_wr);
      level_d  = LVL_W'(32'(level_q) + n_wr - 32'(do_pop));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!flush_i) begin
         for (int unsigned i = 0; i < N_WR; i++) begin
            if (wr_ok[i]) mem_q[wr_idx[i]] <= wr_data_i[i];
         end
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign level_o   = level_q;
   assign empty_o   = (level_q == '0);

endmodule

// File: rtl/triangle_fifo_merger.sv
// N-source triangle FIFO merger: never-stalled priority source plus skid-buffered sources.
// Optional checker: define TRI_MERGE_OVERFLOW_CHK_EN to drive the sticky overflow flag.
module triangle_fifo_merger
   import tri_fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = TRI_DATA_W,
   parameter int unsigned N_SRC     = 2,
   parameter int unsigned BUF_DEPTH = 4
) (
   input  logic                   clk100,
   input  logic                   rst,
   input  logic                   nextFrame,
   triangle_fifo_merger_if.slave  bus
);

   localparam int unsigned LVL_W = clog2(BUF_DEPTH + 1);
   localparam int unsigned SEL_W = idx_w(N_SRC);

   logic [DATA_W-1:0] src_arr [N_SRC];
   logic [DATA_W-1:0] head_data;
   logic [LVL_W-1:0]  level;
   logic              empty;
   logic              pop;
   logic              drop;
   logic [N_SRC-1:0]  wr_en;
   logic [N_SRC-1:0]  byp_mask;
   logic [SEL_W-1:0]  byp_sel;
   logic              byp_vld;
   logic              byp_take;
   logic              out_push_q, out_push_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;

   always_comb begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
         src_arr[i] = bus.src_data[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      byp_vld  = 1'b0;
      byp_sel  = '0;
      byp_mask = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (!byp_vld && bus.src_push[i]) begin
            byp_vld     = 1'b1;
            byp_sel     = SEL_W'(i);
            byp_mask[i] = 1'b1;
         end
      end
   end

   // Bypass only when nothing older is buffered, so per-source order holds.
   assign pop      = !bus.prio_push && !empty;
   assign byp_take = !bus.prio_push && empty && byp_vld;
   assign wr_en    = bus.src_push & ~(byp_take ? byp_mask : '0);

   always_comb begin
      out_push_d = 1'b0;
      out_data_d = '0;
      if (bus.prio_push) begin
         out_push_d = 1'b1;
         out_data_d = bus.prio_data;
      end else if (!empty) begin
         out_push_d = 1'b1;
         out_data_d = head_data;
      end else if (byp_vld) begin
         out_push_d = 1'b1;
         out_data_d = src_arr[byp_sel];
      end
   end

   tri_skid_buf #(
      .DATA_W (DATA_W),
      .N_WR   (N_SRC),
      .DEPTH  (BUF_DEPTH)
   ) u_skid (
      .clk_i     (clk100),
      .rst_i     (rst),
      .flush_i   (nextFrame),
      .wr_en_i   (wr_en),
      .wr_data_i (src_arr),
      .pop_i     (pop),
      .rd_data_o (head_data),
      .level_o   (level),
      .empty_o   (empty),
      .drop_o    (drop)
   );

   always_ff @(posedge clk100 or posedge rst) begin
      if (rst) begin
         out_push_q <= 1'b0;
         out_data_q <= '0;
      end else if (nextFrame) begin
         out_push_q <= 1'b0;
         out_data_q <= '0;
      end else begin
         out_push_q <= out_push_d;
         out_data_q <= out_data_d;
      end
   end

`ifdef TRI_MERGE_OVERFLOW_CHK_EN
   logic overflow_q, overflow_d;

   assign overflow_d = overflow_q | drop | (out_push_q & bus.fifo_full);

   always_ff @(posedge clk100 or posedge rst) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else if (nextFrame) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign bus.overflow = overflow_q;
`else
   logic unused_chk;

   assign unused_chk   = ^{drop, bus.fifo_full};
   assign bus.overflow = 1'b0;
`endif

   assign bus.src_wait  = bus.fifo_prog_full || ((BUF_DEPTH - 32'(level)) < N_SRC);
   assign bus.out_push  = out_push_q;
   assign bus.out_data  = out_data_q;
   assign bus.buf_level = level;

endmodule

// File: tb/tb_triangle_fifo_merger.sv
// Scoreboard bench for triangle_fifo_merger (N_SRC=2, BUF_DEPTH=4).
module tb_triangle_fifo_merger;

   localparam int unsigned DW = 224;

`ifdef TRI_MERGE_OVERFLOW_CHK_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   logic clk100 = 1'b0;
   logic rst;
   logic nextFrame;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [DW-1:0] expq [$];
   logic [DW-1:0] mexp;

   triangle_fifo_merger_if #(.DATA_W(DW), .N_SRC(2), .BUF_DEPTH(4)) bus ();

   triangle_fifo_merger #(.DATA_W(DW), .N_SRC(2), .BUF_DEPTH(4)) dut (
      .clk100    (clk100),
      .rst       (rst),
      .nextFrame (nextFrame),
      .bus       (bus)
   );

   always #5 clk100 = ~clk100;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic p, input logic [DW-1:0] pd, input logic [1:0] sp,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      bus.prio_push = p;
      bus.prio_data = pd;
      bus.src_push  = sp;
      bus.src_data  = {d1, d0};
   endtask

   task automatic idle();
      drive(1'b0, '0, 2'b00, '0, '0);
   endtask

   task automatic cyc();
      @(posedge clk100);
      #1;
   endtask

   // Monitor: every output push must match the oldest outstanding expectation.
   always @(negedge clk100) begin
      if (!rst && bus.out_push) begin
         total++;
         if (expq.size() == 0) begin
            bad++;
            $display("FAIL out_unexpected: got %0h expected none", bus.out_data);
         end else begin
            mexp = expq.pop_front();
            if (bus.out_data !== mexp) begin
               bad++;
               $display("FAIL out_data: got %0h expected %0h", bus.out_data, mexp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst                = 1'b1;
      nextFrame          = 1'b0;
      bus.fifo_full      = 1'b0;
      bus.fifo_prog_full = 1'b0;
      idle();
      repeat (2) @(posedge clk100);
      #1 rst = 1'b0;

      // Reset state
      chk("rst_out_push", 32'(bus.out_push), 32'd0);
      chk("rst_out_data", 32'(bus.out_data == '0), 32'd1);
      chk("rst_level", 32'(bus.buf_level), 32'd0);
      chk("rst_src_wait", 32'(bus.src_wait), 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      cyc();
      chk("idle_out_push", 32'(bus.out_push), 32'd0);

      // Prio A with both sources B, C in the same cycle
      drive(1'b1, DW'(32'hA), 2'b11, DW'(32'hB), DW'(32'hC));
      expq.push_back(DW'(32'hA));
      expq.push_back(DW'(32'hB));
      expq.push_back(DW'(32'hC));
      cyc();
      idle();
      chk("abc_level0", 32'(bus.buf_level), 32'd2);
      cyc();
      chk("abc_level1", 32'(bus.buf_level), 32'd1);
      cyc();
      chk("abc_level2", 32'(bus.buf_level), 32'd0);
      cyc();
      chk("abc_drained", 32'(bus.out_push), 32'd0);

      // Bypass from source 1 with the buffer empty
      drive(1'b0, '0, 2'b10, '0, DW'(32'hD));
      expq.push_back(DW'(32'hD));
      cyc();
      idle();
      chk("byp_push", 32'(bus.out_push), 32'd1);
      chk("byp_data", bus.out_data[31:0], 32'hD);
      chk("byp_level", 32'(bus.buf_level), 32'd0);
      cyc();
      chk("byp_done", 32'(bus.out_push), 32'd0);

      // Sustained prio: sources push in cycles 0 and 1 only
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("stall_wait%0d", k), 32'(bus.src_wait), (k < 2) ? 32'd0 : 32'd1);
         drive(1'b1, DW'(32'h100 + k), (k < 2) ? 2'b11 : 2'b00,
               DW'(32'h200 + k), DW'(32'h300 + k));
         expq.push_back(DW'(32'h100 + k));
         cyc();
      end
      idle();
      chk("stall_level", 32'(bus.buf_level), 32'd4);
      expq.push_back(DW'(32'h200));
      expq.push_back(DW'(32'h300));
      expq.push_back(DW'(32'h201));
      expq.push_back(DW'(32'h301));
      repeat (4) cyc();
      chk("stall_drained", 32'(bus.buf_level), 32'd0);
      chk("stall_wait_end", 32'(bus.src_wait), 32'd0);

      // Programmable full alone raises src_wait
      bus.fifo_prog_full = 1'b1;
      #1 chk("pfull_wait", 32'(bus.src_wait), 32'd1);
      bus.fifo_prog_full = 1'b0;
      #1 chk("pfull_clear", 32'(bus.src_wait), 32'd0);
      cyc();

      // Overflow: fill under prio, then push one more
      drive(1'b1, DW'(32'h400), 2'b11, DW'(32'h500), DW'(32'h600));
      expq.push_back(DW'(32'h400));
      cyc();
      drive(1'b1, DW'(32'h401), 2'b11, DW'(32'h501), DW'(32'h601));
      expq.push_back(DW'(32'h401));
      cyc();
      chk("ovf_full", 32'(bus.buf_level), 32'd4);
      chk("ovf_pre", 32'(bus.overflow), 32'd0);
      drive(1'b1, DW'(32'h402), 2'b01, DW'(32'h502), '0);
      expq.push_back(DW'(32'h402));
      cyc();
      idle();
      chk("ovf_level", 32'(bus.buf_level), 32'd4);
      chk("ovf_flag", 32'(bus.overflow), 32'(OVF_EXP));
      nextFrame = 1'b1;
      cyc();
      nextFrame = 1'b0;
      chk("nf_level", 32'(bus.buf_level), 32'd0);
      chk("nf_overflow", 32'(bus.overflow), 32'd0);
      chk("nf_out_push", 32'(bus.out_push), 32'd0);
      cyc();
      chk("nf_idle", 32'(bus.out_push), 32'd0);

      // Asynchronous reset with three items buffered
      drive(1'b1, DW'(32'h700), 2'b11, DW'(32'h800), DW'(32'h900));
      expq.push_back(DW'(32'h700));
      cyc();
      drive(1'b1, DW'(32'h701), 2'b01, DW'(32'h801), '0);
      expq.push_back(DW'(32'h701));
      cyc();
      #5;
      chk("ar_level_pre", 32'(bus.buf_level), 32'd3);
      rst = 1'b1;
      #1;
      chk("ar_out_push", 32'(bus.out_push), 32'd0);
      chk("ar_out_data", 32'(bus.out_data == '0), 32'd1);
      chk("ar_level", 32'(bus.buf_level), 32'd0);
      chk("ar_overflow", 32'(bus.overflow), 32'd0);
      chk("ar_src_wait", 32'(bus.src_wait), 32'd0);
      idle();
      #1 rst = 1'b0;
      cyc();
      chk("ar_after", 32'(bus.out_push), 32'd0);

      repeat (3) cyc();
      chk("sb_empty", 32'(expq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
